// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, loader and memory-port signals around the instruction-memory arbiter.
// Handshake: a request transfers in a cycle with req && gnt; the requester holds req and fields until then.
interface imem_arbiter_if;
    logic        f_req;
    logic [11:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_fault;

    logic        l_req;
    logic        l_we;
    logic [11:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  l_be;
    logic        l_lock;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        l_err;

    logic [11:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [15:0] conflict_cnt;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata, f_fault,
        input  l_req, l_we, l_addr, l_wdata, l_be, l_lock,
        output l_gnt, l_rvalid, l_rdata, l_err,
        output mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_rdata,
        output conflict_cnt
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata, f_fault,
        output l_req, l_we, l_addr, l_wdata, l_be, l_lock,
        input  l_gnt, l_rvalid, l_rdata, l_err,
        input  mem_addr, mem_we, mem_be, mem_wdata,
        output mem_rdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter between fetch and loader for a single-ported byte-addressed instruction memory.
// Grants and memory port are combinational; responses are registered one cycle after the grant.
module imem_arbiter #(
    parameter int MEM_SIZE = 4096
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);
    localparam logic [12:0] LAST_BYTE = 13'(MEM_SIZE - 1);
    localparam logic [0:0]  RR_FETCH  = 1'b0;
    localparam logic [0:0]  RR_LOADER = 1'b1;

    logic [0:0]  r_rr_last;
    logic        r_f_rvalid;
    logic [31:0] r_f_rdata;
    logic        r_f_fault;
    logic        r_l_rvalid;
    logic [31:0] r_l_rdata;
    logic        r_l_err;
    logic [15:0] r_conflict_cnt;

    logic w_f_legal;
    logic w_l_legal;
    logic w_f_gnt;
    logic w_l_gnt;
    logic w_both;

    // Bound check done at 13 bits so addr+3 cannot wrap back into range.
    assign w_f_legal = (bus.f_addr[1:0] == 2'b00) && (({1'b0, bus.f_addr} + 13'd3) <= LAST_BYTE);
    assign w_l_legal = (bus.l_addr[1:0] == 2'b00) && (({1'b0, bus.l_addr} + 13'd3) <= LAST_BYTE);
    assign w_both    = bus.f_req && bus.l_req;

    // Lock gives the loader absolute priority; otherwise the requester not served last wins a tie.
    assign w_f_gnt = !rst && bus.f_req && !bus.l_lock && (!bus.l_req || (r_rr_last == RR_LOADER));
    assign w_l_gnt = !rst && bus.l_req && (bus.l_lock || !bus.f_req || (r_rr_last == RR_FETCH));

    assign bus.f_gnt = w_f_gnt;
    assign bus.l_gnt = w_l_gnt;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        if (w_f_gnt && w_f_legal) begin
            bus.mem_addr = bus.f_addr;
        end else if (w_l_gnt && w_l_legal) begin
            bus.mem_addr = bus.l_addr;
            if (bus.l_we) begin
                bus.mem_we    = 1'b1;
                bus.mem_be    = bus.l_be;
                bus.mem_wdata = bus.l_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last      <= RR_LOADER;
            r_f_rvalid     <= 1'b0;
            r_f_rdata      <= '0;
            r_f_fault      <= 1'b0;
            r_l_rvalid     <= 1'b0;
            r_l_rdata      <= '0;
            r_l_err        <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_f_gnt) begin
                r_rr_last <= RR_FETCH;
            end else if (w_l_gnt) begin
                r_rr_last <= RR_LOADER;
            end

            r_f_rvalid <= w_f_gnt;
            if (w_f_gnt) begin
                r_f_fault <= !w_f_legal;
                r_f_rdata <= w_f_legal ? bus.mem_rdata : 32'd0;
            end

            r_l_rvalid <= w_l_gnt;
            if (w_l_gnt) begin
                r_l_err   <= !w_l_legal;
                r_l_rdata <= (w_l_legal && !bus.l_we) ? bus.mem_rdata : 32'd0;
            end

            if (w_both && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign bus.f_rvalid     = r_f_rvalid;
    assign bus.f_rdata      = r_f_rdata;
    assign bus.f_fault      = r_f_fault;
    assign bus.l_rvalid     = r_l_rvalid;
    assign bus.l_rdata      = r_l_rdata;
    assign bus.l_err        = r_l_err;
    assign bus.conflict_cnt = r_conflict_cnt;
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: byte-array memory, directed scenarios plus random traffic,
// checked against a reference model of the arbitration and memory rules.
module tb_imem_arbiter;
    localparam int MEM_SIZE = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    imem_arbiter_if bus();

    imem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory seen by the DUT
    logic [7:0] env_mem [MEM_SIZE] = '{default: 8'h00};
    assign bus.mem_rdata = {env_mem[bus.mem_addr + 12'd3], env_mem[bus.mem_addr + 12'd2],
                            env_mem[bus.mem_addr + 12'd1], env_mem[bus.mem_addr]};
    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_be[i]) env_mem[bus.mem_addr + 12'(i)] <= bus.mem_wdata[8*i +: 8];
            end
        end
    end

    // Reference model state
    byte unsigned ref_mem [MEM_SIZE];
    bit           last_was_loader = 1'b1;
    int           ref_conflicts   = 0;

    // Expected responses: {due_cycle[31:0], flag, data[31:0]}
    logic [64:0] f_exp_q[$];
    logic [64:0] l_exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_legal(input int a);
        return ((a % 4) == 0) && (a + 3 <= MEM_SIZE - 1);
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    // Drive one cycle of requests, check grant-cycle outputs, update the model.
    task automatic step(input logic fr, input logic [11:0] fa,
                        input logic lr, input logic lw, input logic [11:0] la,
                        input logic [31:0] lwd, input logic [3:0] lbe, input logic lk,
                        output logic fg, output logic lg);
        logic ef, el, ewe, chk_addr;
        logic [11:0] eaddr;
        bus.f_req = fr; bus.f_addr = fa;
        bus.l_req = lr; bus.l_we = lw; bus.l_addr = la;
        bus.l_wdata = lwd; bus.l_be = lbe; bus.l_lock = lk;
        @(negedge clk);
        ef = 1'b0; el = 1'b0;
        if (lk) el = lr;
        else if (fr && lr) begin
            if (last_was_loader) ef = 1'b1; else el = 1'b1;
        end else begin
            ef = fr; el = lr;
        end
        check("grants", 64'({bus.f_gnt, bus.l_gnt}), 64'({ef, el}));

        ewe = 1'b0; eaddr = 12'd0; chk_addr = 1'b1;
        if (ef) begin
            if (is_legal(int'(fa))) eaddr = fa; else chk_addr = 1'b0;
        end else if (el) begin
            if (is_legal(int'(la))) begin eaddr = la; ewe = lw; end else chk_addr = 1'b0;
        end
        check("mem_we", 64'(bus.mem_we), 64'(ewe));
        if (chk_addr) check("mem_addr", 64'(bus.mem_addr), 64'(eaddr));
        if (ewe) check("mem_be_wdata", {28'd0, bus.mem_be, bus.mem_wdata}, {28'd0, lbe, lwd});
        check("conflict_cnt", 64'(bus.conflict_cnt), 64'(ref_conflicts));

        if (fr && lr && ref_conflicts < 16'hFFFF) ref_conflicts++;
        if (ef) begin
            if (is_legal(int'(fa))) f_exp_q.push_back({32'(cyc + 1), 1'b0, ref_word(int'(fa))});
            else                    f_exp_q.push_back({32'(cyc + 1), 1'b1, 32'd0});
            last_was_loader = 1'b0;
        end else if (el) begin
            if (!is_legal(int'(la))) l_exp_q.push_back({32'(cyc + 1), 1'b1, 32'd0});
            else if (lw) begin
                for (int i = 0; i < 4; i++) if (lbe[i]) ref_mem[int'(la) + i] = lwd[8*i +: 8];
                l_exp_q.push_back({32'(cyc + 1), 1'b0, 32'd0});
            end else l_exp_q.push_back({32'(cyc + 1), 1'b0, ref_word(int'(la))});
            last_was_loader = 1'b1;
        end
        fg = ef; lg = el;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        logic g1, g2;
        for (int i = 0; i < n; i++) step(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0, 4'd0, 1'b0, g1, g2);
    endtask

    // Assert reset mid-cycle; responses must vanish at once and grants stay low.
    task automatic do_reset();
        bus.f_req = 1'b0; bus.l_req = 1'b0; bus.l_lock = 1'b0;
        rst = 1'b1;
        f_exp_q.delete();
        l_exp_q.delete();
        last_was_loader = 1'b1;
        ref_conflicts = 0;
        #1;
        check("rst_rvalid", 64'({bus.f_rvalid, bus.l_rvalid}), 64'd0);
        check("rst_rdata", {bus.f_rdata, bus.l_rdata}, 64'd0);
        check("rst_flags_cnt", 64'({bus.f_fault, bus.l_err, bus.conflict_cnt}), 64'd0);
        bus.f_req = 1'b1; bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 12'h040;
        bus.l_be = 4'hF; bus.l_wdata = 32'hDEAD_BEEF;
        #1;
        check("rst_no_grant_we", 64'({bus.f_gnt, bus.l_gnt, bus.mem_we}), 64'd0);
        bus.f_req = 1'b0; bus.l_req = 1'b0; bus.l_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [11:0] rand_addr();
        logic [11:0] a;
        case ($urandom_range(0, 9))
            0: begin a = 12'($urandom); if (a[1:0] == 2'b00) a[0] = 1'b1; end
            1: a = 12'hFFC;
            2: a = 12'hFFE;
            default: a = 12'h100 + 12'(4 * $urandom_range(0, 7));
        endcase
        return a;
    endfunction

    // Response monitor
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst) begin
            if (bus.f_rvalid) begin
                if (f_exp_q.size() == 0) check("f_unexpected_rvalid", 64'd1, 64'd0);
                else begin
                    e = f_exp_q.pop_front();
                    check("f_resp", {31'd0, bus.f_fault, bus.f_rdata}, {31'd0, e[32:0]});
                    check("f_resp_cycle", 64'(cyc), 64'(e[64:33]));
                end
            end else if (f_exp_q.size() > 0 && int'(f_exp_q[0][64:33]) <= cyc) begin
                check("f_missing_rvalid", 64'd0, 64'd1);
                void'(f_exp_q.pop_front());
            end
            if (bus.l_rvalid) begin
                if (l_exp_q.size() == 0) check("l_unexpected_rvalid", 64'd1, 64'd0);
                else begin
                    e = l_exp_q.pop_front();
                    check("l_resp", {31'd0, bus.l_err, bus.l_rdata}, {31'd0, e[32:0]});
                    check("l_resp_cycle", 64'(cyc), 64'(e[64:33]));
                end
            end else if (l_exp_q.size() > 0 && int'(l_exp_q[0][64:33]) <= cyc) begin
                check("l_missing_rvalid", 64'd0, 64'd1);
                void'(l_exp_q.pop_front());
            end
        end
    end

    initial begin
        logic fg, lg, f_pend, l_pend, lw, lk;
        logic [11:0] fa, la;
        logic [31:0] lwd;
        logic [3:0]  lbe;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'h00;
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0;
        bus.l_wdata = '0; bus.l_be = '0; bus.l_lock = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_f", {30'd0, bus.f_rvalid, bus.f_fault, bus.f_rdata}, 64'd0);
        check("reset_l", {30'd0, bus.l_rvalid, bus.l_err, bus.l_rdata}, 64'd0);
        check("reset_cnt", 64'(bus.conflict_cnt), 64'd0);
        rst = 1'b0;

        // Single fetch after a loader write
        step(1'b0, 12'd0, 1'b1, 1'b1, 12'h010, 32'h0000_0013, 4'hF, 1'b0, fg, lg);
        step(1'b1, 12'h010, 1'b0, 1'b0, 12'd0, 32'd0, 4'd0, 1'b0, fg, lg);
        idle(1);

        // Alternation from reset state: F,L,F,L
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 12'h010, 1'b1, 1'b0, 12'h010, 32'd0, 4'd0, 1'b0, fg, lg);
        idle(1);
        check("conflict_after_4", 64'(bus.conflict_cnt), 64'd4);

        // Lock then release
        for (int i = 0; i < 3; i++)
            step(1'b1, 12'h010, 1'b1, 1'b0, 12'h010, 32'd0, 4'd0, 1'b1, fg, lg);
        step(1'b1, 12'h010, 1'b1, 1'b0, 12'h010, 32'd0, 4'd0, 1'b0, fg, lg);
        check("fetch_after_lock", 64'(fg), 64'd1);
        idle(1);

        // Byte-lane write
        step(1'b0, 12'd0, 1'b1, 1'b1, 12'h020, 32'hAABB_CCDD, 4'hF, 1'b0, fg, lg);
        step(1'b0, 12'd0, 1'b1, 1'b1, 12'h020, 32'h1122_3344, 4'b0101, 1'b0, fg, lg);
        step(1'b0, 12'd0, 1'b1, 1'b0, 12'h020, 32'd0, 4'd0, 1'b0, fg, lg);
        check("byte_lane_model", 64'(ref_word(32)), 64'h0000_0000_AA22_CC44);
        step(1'b0, 12'd0, 1'b1, 1'b1, 12'h024, 32'hFFFF_FFFF, 4'h0, 1'b0, fg, lg);
        step(1'b0, 12'd0, 1'b1, 1'b0, 12'h024, 32'd0, 4'd0, 1'b0, fg, lg);

        // Faults and bounds
        step(1'b0, 12'd0, 1'b1, 1'b1, 12'hFFC, 32'h5566_7788, 4'hF, 1'b0, fg, lg);
        step(1'b1, 12'h002, 1'b0, 1'b0, 12'd0, 32'd0, 4'd0, 1'b0, fg, lg);
        step(1'b1, 12'hFFC, 1'b0, 1'b0, 12'd0, 32'd0, 4'd0, 1'b0, fg, lg);
        step(1'b0, 12'd0, 1'b1, 1'b1, 12'hFFE, 32'h0BAD_0BAD, 4'hF, 1'b0, fg, lg);
        step(1'b0, 12'd0, 1'b1, 1'b0, 12'hFFC, 32'd0, 4'd0, 1'b0, fg, lg);
        idle(1);

        // Reset the cycle after a grant
        step(1'b1, 12'h010, 1'b0, 1'b0, 12'd0, 32'd0, 4'd0, 1'b0, fg, lg);
        do_reset();
        step(1'b1, 12'h020, 1'b1, 1'b0, 12'h010, 32'd0, 4'd0, 1'b0, fg, lg);
        check("first_conflict_fetch", 64'(fg), 64'd1);
        idle(1);

        // Random traffic obeying the hold rule
        f_pend = 1'b0; l_pend = 1'b0;
        fa = 12'd0; la = 12'd0; lw = 1'b0; lwd = 32'd0; lbe = 4'd0;
        for (int n = 0; n < 600; n++) begin
            if (!f_pend) begin
                f_pend = ($urandom_range(0, 2) != 0);
                fa = rand_addr();
            end
            if (!l_pend) begin
                l_pend = ($urandom_range(0, 2) != 0);
                lw  = 1'($urandom_range(0, 1));
                la  = rand_addr();
                lwd = $urandom;
                lbe = 4'($urandom_range(0, 15));
            end
            lk = ($urandom_range(0, 7) == 0);
            step(f_pend, fa, l_pend, lw, la, lwd, lbe, lk, fg, lg);
            if (fg) f_pend = 1'b0;
            if (lg) l_pend = 1'b0;
        end
        idle(3);
        check("f_queue_drained", 64'(f_exp_q.size()), 64'd0);
        check("l_queue_drained", 64'(l_exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter sharing the single-ported, byte-addressed instruction memory between the core's fetch unit and the program loader (boot/debug). Each cycle it grants at most one requester, drives the memory port from the winner and returns registered read data one cycle later. It also checks alignment and bounds so that no illegal access ever reaches the memory array.

## Interface
- MEM_SIZE, 4096: memory size in bytes; the address width is fixed at 12.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request (read).
- f_addr  in  12  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  fetch response valid; one-cycle pulse.
- f_rdata  out  32  fetch response word, little-endian.
- f_fault  out  1  fetch response is a fault; qualified by f_rvalid.
- l_req  in  1  loader request.
- l_we  in  1  loader request is a write (1) or a read (0).
- l_addr  in  12  loader byte address.
- l_wdata  in  32  loader write word.
- l_be  in  4  loader byte enables; bit i writes byte addr+i.
- l_lock  in  1  loader exclusive mode; fetch is never granted while this is high.
- l_gnt  out  1  loader request accepted this cycle (combinational).
- l_rvalid  out  1  loader response valid; pulses for reads and writes.
- l_rdata  out  32  loader read word; holds 0 after a write or an error.
- l_err  out  1  loader response is an error; qualified by l_rvalid.
- mem_addr  out  12  memory byte address (word-aligned when used).
- mem_we  out  1  memory write strobe; the memory writes on the clk edge.
- mem_be  out  4  memory byte enables.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read word {b[a+3],b[a+2],b[a+1],b[a]}.
- conflict_cnt  out  16  saturating count of cycles in which f_req and l_req were both high.

## Operation
- **Legal access:** addr[1:0]==0 and addr+3 <= MEM_SIZE-1. Compute the bound check at 13 bits so the address cannot wrap.
- **Arbitration:**
  - If only one request is high, that requester wins.
  - If both are high, round-robin decides: the requester not granted most recently wins.
  - The rr pointer (last granted) updates on every grant.
  - l_lock=1 forces f_gnt=0; a loader request then always wins, and fetch waits regardless of the rr pointer.
- **Illegal access:**
  - The request is still granted, but mem_we=0 and the array is not touched.
  - Next cycle, the response pulses with the fault/err flag set and rdata=0.
- **Legal fetch:** mem_addr=f_addr and mem_we=0. mem_rdata is captured into f_rdata.
- **Legal loader read:** the same path as a legal fetch, returning on l_rdata.
- **Legal loader write:** mem_we=1 only in the grant cycle, with mem_be=l_be. l_rdata is 0 on the response. A write with l_be=0 is legal and changes no bytes.
- **Idle defaults:** when nothing is granted, mem_addr=0, mem_we=0, mem_be=0 and mem_wdata=0.
- **Request hold rule:** a requester keeps req and its fields stable until it sees gnt. Ungranted requests are not queued inside this block.
- **conflict_cnt:** increments on every cycle with f_req & l_req, whether or not lock is set, and saturates at 0xFFFF.

## Timing
- **Grant:** f_gnt/l_gnt and all mem_* outputs are combinational from the requests, l_lock and the rr pointer, within the request cycle.
- **Response:** arrives exactly 1 cycle after the grant, as a 1-cycle rvalid pulse. Throughput is one access per cycle in total.
- **Back-to-back grants** to the same requester produce consecutive rvalid pulses.
- **Read/write ordering:** a loader write in cycle N is visible to any read granted in cycle N+1.
- **Reset values:**
  - f_rvalid=0, f_rdata=0, f_fault=0.
  - l_rvalid=0, l_rdata=0, l_err=0.
  - conflict_cnt=0.
  - rr pointer = loader, so fetch wins the first conflict.
- **Reset mid-operation:** an in-flight response is dropped (rvalid=0 immediately). A write strobe in the reset cycle must not be issued, so all grants are forced to 0 while rst is high.

## Test plan
- **Single fetch:** write 0x00000013 to addr 0x010, then fetch 0x010 → f_gnt in the same cycle; next cycle f_rvalid=1, f_rdata=0x00000013, f_fault=0.
- **Contention, alternation:** hold f_req and l_req (read) for 4 cycles after reset → grants go F,L,F,L; conflict_cnt=4; each requester gets 2 responses.
- **Lock:** l_lock=1 with both requesting for 3 cycles → l_gnt=1 and f_gnt=0 in all 3 cycles. Drop lock → fetch is granted the next cycle.
- **Byte-lane write:** fill 0x020 with 0xAABBCCDD, then write 0x11223344 with l_be=0b0101 → a read of 0x020 returns 0xAA22CC44.
- **Fault and bound:** fetch 0x002 → f_fault=1, f_rdata=0. Fetch 0xFFC → legal. Loader write to 0xFFE → l_err=1 with mem_we never asserted, and a read of 0xFFC is unchanged.
- **Reset mid-access:** assert rst in the cycle after a grant → f_rvalid=0 at once. After release, conflict_cnt=0 and fetch wins the first conflict.
